wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage. Consumes the MEM/WB pipeline register outputs and drives the scalar and vector register-file write ports.
- Scalar path: selects between the ALU result and the loaded word. Applies byte/halfword extraction and sign or zero extension to loads.
- Vector path: serialises each 64-bit vector result into two 32-bit beats on the vector-RF write port.
- Asserts a stall back to the MEM/WB register's enable while a two-beat vector write is in progress.

Parameters:
- XLEN, 32, scalar data width; the vector element is 2*XLEN.
- NREG_LOG2, 5, scalar register index width; the vector-RF address is NREG_LOG2+1 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- RamDataW  in  32  raw 32-bit word read from data RAM
- LoadedBytesSelect  in  2  byte offset of the load address (AluOut[1:0])
- RegWriteW  in  3  write/load type: 0 none, 1 LB, 2 LH, 3 LW (also plain ALU write), 4 LBU, 5 LHU, 6/7 reserved
- MemToRegW  in  1  1 = write loaded data, 0 = write ResultW
- ResultW  in  32  ALU/CSR result
- RdW  in  5  destination register index
- VecDataW  in  64  vector result
- VecRegWriteW  in  1  vector write request
- RegFileWe  out  1  scalar RF write enable (registered)
- RegFileWaddr  out  5  scalar RF write address (registered)
- RegFileWdata  out  32  scalar RF write data (registered)
- VecFileWe  out  1  vector RF write enable (registered)
- VecFileWaddr  out  6  vector RF half-register address {RdW, beat} (registered)
- VecFileWdata  out  32  vector RF beat data (registered)
- WbStall  out  1  combinational; when high, the MEM/WB register is held (drives its en low)

Behaviour:
- Reset: every registered output is 0 and the FSM is in IDLE. WbStall is 0 while rst is high.
- Latency: all RF write outputs are registered. A write presented on the WB inputs at edge N appears on the ports after edge N+1. The forwarding/hazard unit accounts for this extra cycle.
- Load extension (combinational, ahead of the output register):
  - LB/LBU take byte RamDataW[8*sel +: 8].
  - LH/LHU take halfword RamDataW[16*sel[1] +: 16]; sel[0] is ignored (misaligned access is not trapped here).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - When MemToRegW=0, write data is ResultW regardless of load type.
- Scalar write enable: RegFileWe is 1 when RegWriteW is in 1..5 and RdW != 0.
  - RegWriteW 6/7 produce no write.
  - Rd=0 never writes; RegFileWdata is then 0.
- Vector FSM, two states: IDLE and HIGH.
  - IDLE with VecRegWriteW=1: register low beat (VecFileWe=1, VecFileWaddr={RdW,0}, VecFileWdata=VecDataW[31:0]). WbStall=1 in this cycle. Go to HIGH.
  - HIGH: inputs are frozen by the stall. Register high beat (addr {RdW,1}, data VecDataW[63:32]). WbStall=0. Return to IDLE.
  - IDLE with VecRegWriteW=0: VecFileWe registers 0.
- An instruction with both scalar and vector writes issues the scalar write in the IDLE (first) cycle only. In the HIGH cycle the scalar write is suppressed (RegFileWe=0), so the frozen inputs never cause a duplicate write.
- Back-to-back vector writes: the second vector instruction enters WB after HIGH completes and restarts at IDLE. The throughput is 2 cycles per vector write with no beat lost.
- Reset asserted in HIGH: the FSM returns to IDLE, the high beat is not written, and outputs are 0 on the next cycle.
- Vector writes have no Rd=0 exclusion; vector register 0 is writable.

Decomposition:
- Shared package rv_wb_pkg holds:
  - RegWriteW encodings (NOREGWRITE, LB, LH, LW, LBU, LHU)
  - vector FSM state typedef (IDLE, HIGH)
  - XLEN
- One natural sub-module, load_ext: purely combinational byte/half select plus extension, reusable by the debug memory reader.

Test Plan:
- Reset: hold rst 3 cycles with VecRegWriteW=1, RegWriteW=3 -> all outputs 0, WbStall 0. Release -> normal operation starts the next cycle.
- Loads: RamDataW=0x80F1_7F82.
  - LB sel=0 -> 0xFFFF_FF82; LBU sel=0 -> 0x0000_0082; LB sel=1 -> 0x0000_007F.
  - LH sel=2 -> 0xFFFF_80F1; LHU sel=3 -> 0x0000_80F1.
  - Each appears one cycle later with RegFileWe=1 and the matching Rd.
- ALU path: MemToRegW=0, RegWriteW=3, ResultW=0x1234_5678, RdW=7 -> RegFileWe=1, Waddr=7, Wdata=0x1234_5678. Repeat with RdW=0 -> RegFileWe=0. Repeat with RegWriteW=6 -> RegFileWe=0.
- Vector: VecDataW=0xDEAD_BEEF_0123_4567, RdW=5.
  - WbStall=1 for exactly one cycle.
  - Beats are (addr 10, 0x0123_4567) then (addr 11, 0xDEAD_BEEF) on consecutive cycles.
  - Issue two vector instructions back to back -> four beats, two stall pulses, none dropped.
- Combined: VecRegWriteW=1 with RegWriteW=3, RdW=9 -> exactly one scalar write to r9, coincident with the low beat.
- Reset in HIGH: assert rst in the cycle after the low beat -> no high beat is written and the FSM restarts in IDLE.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared writeback-stage types: load/write encodings, vector FSM states, data width.
package rv_wb_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        NOREGWRITE = 3'd0,
        LB         = 3'd1,
        LH         = 3'd2,
        LW         = 3'd3,
        LBU        = 3'd4,
        LHU        = 3'd5
    } reg_write_e;

    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } vec_state_e;

endpackage

// File: rtl/load_ext.sv
// Byte/halfword extraction with sign or zero extension of a raw RAM word.
module load_ext
    import rv_wb_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_sel,
    input  reg_write_e      i_type,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword select ignores sel[0]; misalignment is not trapped here.
    assign w_byte = i_word[{i_sel, 3'b000} +: 8];
    assign w_half = i_word[{i_sel[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_word;
        case (i_type)
            LB:      o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LBU:     o_data = {{(XLEN-8){1'b0}}, w_byte};
            LH:      o_data = {{(XLEN-16){w_half[15]}}, w_half};
            LHU:     o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: scalar RF write with load extension, two-beat vector RF write with stall.
module wb_stage
    import rv_wb_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREG_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      RamDataW,
    input  logic [1:0]           LoadedBytesSelect,
    input  logic [2:0]           RegWriteW,
    input  logic                 MemToRegW,
    input  logic [XLEN-1:0]      ResultW,
    input  logic [NREG_LOG2-1:0] RdW,
    input  logic [2*XLEN-1:0]    VecDataW,
    input  logic                 VecRegWriteW,
    output logic                 RegFileWe,
    output logic [NREG_LOG2-1:0] RegFileWaddr,
    output logic [XLEN-1:0]      RegFileWdata,
    output logic                 VecFileWe,
    output logic [NREG_LOG2:0]   VecFileWaddr,
    output logic [XLEN-1:0]      VecFileWdata,
    output logic                 WbStall
);

    vec_state_e             r_state;
    vec_state_e             w_state_next;
    logic [XLEN-1:0]        w_load_data;
    logic [XLEN-1:0]        w_scalar_data;
    logic                   w_type_valid;
    logic                   w_rf_we;
    logic [NREG_LOG2-1:0]   w_rf_waddr;
    logic [XLEN-1:0]        w_rf_wdata;
    logic                   w_vf_we;
    logic [NREG_LOG2:0]     w_vf_waddr;
    logic [XLEN-1:0]        w_vf_wdata;

    load_ext u_load_ext (
        .i_word (RamDataW),
        .i_sel  (LoadedBytesSelect),
        .i_type (reg_write_e'(RegWriteW)),
        .o_data (w_load_data)
    );

    assign w_type_valid  = (RegWriteW != 3'(NOREGWRITE)) && (RegWriteW <= 3'(LHU));
    assign w_scalar_data = MemToRegW ? w_load_data : ResultW;

    // Hold MEM/WB only during the low-beat cycle; HIGH consumes the frozen inputs.
    assign WbStall = !rst && (r_state == IDLE) && VecRegWriteW;

    always_comb begin
        w_state_next = r_state;
        w_rf_we      = 1'b0;
        w_rf_waddr   = '0;
        w_rf_wdata   = '0;
        w_vf_we      = 1'b0;
        w_vf_waddr   = '0;
        w_vf_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_type_valid && (RdW != '0)) begin
                    w_rf_we    = 1'b1;
                    w_rf_waddr = RdW;
                    w_rf_wdata = w_scalar_data;
                end
                if (VecRegWriteW) begin
                    w_vf_we      = 1'b1;
                    w_vf_waddr   = {RdW, 1'b0};
                    w_vf_wdata   = VecDataW[XLEN-1:0];
                    w_state_next = HIGH;
                end
            end
            HIGH: begin
                // Scalar write already issued in IDLE; suppress the duplicate.
                w_vf_we      = 1'b1;
                w_vf_waddr   = {RdW, 1'b1};
                w_vf_wdata   = VecDataW[2*XLEN-1:XLEN];
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegFileWe    <= 1'b0;
            RegFileWaddr <= '0;
            RegFileWdata <= '0;
            VecFileWe    <= 1'b0;
            VecFileWaddr <= '0;
            VecFileWdata <= '0;
        end else begin
            RegFileWe    <= w_rf_we;
            RegFileWaddr <= w_rf_waddr;
            RegFileWdata <= w_rf_wdata;
            VecFileWe    <= w_vf_we;
            VecFileWaddr <= w_vf_waddr;
            VecFileWdata <= w_vf_wdata;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage: expected writes queued at drive, compared a cycle later.
module tb_wb_stage;

    typedef struct {
        logic        full;
        logic        rwe;
        logic [4:0]  ra;
        logic [31:0] rd;
        logic        vwe;
        logic [5:0]  va;
        logic [31:0] vd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RamDataW;
    logic [1:0]  LoadedBytesSelect;
    logic [2:0]  RegWriteW;
    logic        MemToRegW;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic [63:0] VecDataW;
    logic        VecRegWriteW;
    logic        RegFileWe;
    logic [4:0]  RegFileWaddr;
    logic [31:0] RegFileWdata;
    logic        VecFileWe;
    logic [5:0]  VecFileWaddr;
    logic [31:0] VecFileWdata;
    logic        WbStall;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    wb_stage #(.XLEN(32), .NREG_LOG2(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .RamDataW          (RamDataW),
        .LoadedBytesSelect (LoadedBytesSelect),
        .RegWriteW         (RegWriteW),
        .MemToRegW         (MemToRegW),
        .ResultW           (ResultW),
        .RdW               (RdW),
        .VecDataW          (VecDataW),
        .VecRegWriteW      (VecRegWriteW),
        .RegFileWe         (RegFileWe),
        .RegFileWaddr      (RegFileWaddr),
        .RegFileWdata      (RegFileWdata),
        .VecFileWe         (VecFileWe),
        .VecFileWaddr      (VecFileWaddr),
        .VecFileWdata      (VecFileWdata),
        .WbStall           (WbStall)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic full, input logic rwe, input logic [4:0] ra,
                                input logic [31:0] rd, input logic vwe, input logic [5:0] va,
                                input logic [31:0] vd);
        exp_t e;
        e.full = full; e.rwe = rwe; e.ra = ra; e.rd = rd;
        e.vwe = vwe; e.va = va; e.vd = vd;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        chk("rf_we", 64'(RegFileWe), 64'(e.rwe));
        if (e.full || e.rwe) begin
            chk("rf_waddr", 64'(RegFileWaddr), 64'(e.ra));
            chk("rf_wdata", 64'(RegFileWdata), 64'(e.rd));
        end
        chk("vf_we", 64'(VecFileWe), 64'(e.vwe));
        if (e.full || e.vwe) begin
            chk("vf_waddr", 64'(VecFileWaddr), 64'(e.va));
            chk("vf_wdata", 64'(VecFileWdata), 64'(e.vd));
        end
    endtask

    task automatic step(input logic r, input logic vw, input logic [2:0] rw, input logic mtr,
                        input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] res,
                        input logic [63:0] vd, input logic stall, input exp_t e);
        @(negedge clk);
        check_out();
        rst = r; VecRegWriteW = vw; RegWriteW = rw; MemToRegW = mtr;
        LoadedBytesSelect = sel; RdW = rd; ResultW = res; VecDataW = vd;
        #1;
        chk("wb_stall", 64'(WbStall), 64'(stall));
        q.push_back(e);
    endtask

    initial begin
        exp_t z;
        z = mk(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        rst = 1'b1; RamDataW = 32'h80F1_7F82; LoadedBytesSelect = 2'd0; RegWriteW = 3'd3;
        MemToRegW = 1'b0; ResultW = 32'hAAAA_AAAA; RdW = 5'd9;
        VecDataW = 64'h1111_2222_3333_4444; VecRegWriteW = 1'b1;

        // Reset held with pending scalar and vector writes
        for (int i = 0; i < 3; i++)
            step(1, 1, 3'd3, 0, 2'd0, 5'd9, 32'hAAAA_AAAA, 64'h1111_2222_3333_4444, 0, z);
        step(0, 0, 3'd0, 0, 2'd0, 5'd0, 32'd0, 64'd0, 0, z);

        // Load extension
        step(0, 0, 3'd1, 1, 2'd0, 5'd1, 32'd0, 64'd0, 0, mk(0, 1, 5'd1, 32'hFFFF_FF82, 0, 6'd0, 32'd0));
        step(0, 0, 3'd4, 1, 2'd0, 5'd2, 32'd0, 64'd0, 0, mk(0, 1, 5'd2, 32'h0000_0082, 0, 6'd0, 32'd0));
        step(0, 0, 3'd1, 1, 2'd1, 5'd3, 32'd0, 64'd0, 0, mk(0, 1, 5'd3, 32'h0000_007F, 0, 6'd0, 32'd0));
        step(0, 0, 3'd2, 1, 2'd2, 5'd4, 32'd0, 64'd0, 0, mk(0, 1, 5'd4, 32'hFFFF_80F1, 0, 6'd0, 32'd0));
        step(0, 0, 3'd5, 1, 2'd3, 5'd5, 32'd0, 64'd0, 0, mk(0, 1, 5'd5, 32'h0000_80F1, 0, 6'd0, 32'd0));
        step(0, 0, 3'd3, 1, 2'd1, 5'd6, 32'd0, 64'd0, 0, mk(0, 1, 5'd6, 32'h80F1_7F82, 0, 6'd0, 32'd0));

        // ALU path, Rd=0 suppression, reserved type
        step(0, 0, 3'd3, 0, 2'd0, 5'd7, 32'h1234_5678, 64'd0, 0, mk(0, 1, 5'd7, 32'h1234_5678, 0, 6'd0, 32'd0));
        step(0, 0, 3'd3, 0, 2'd0, 5'd0, 32'h1234_5678, 64'd0, 0, z);
        step(0, 0, 3'd6, 0, 2'd0, 5'd7, 32'h1234_5678, 64'd0, 0, mk(0, 0, 5'd0, 32'd0, 0, 6'd0, 32'd0));
        step(0, 0, 3'd7, 1, 2'd0, 5'd7, 32'h1234_5678, 64'd0, 0, mk(0, 0, 5'd0, 32'd0, 0, 6'd0, 32'd0));

        // Single vector write, then two back to back
        step(0, 1, 3'd0, 0, 2'd0, 5'd5, 32'd0, 64'hDEAD_BEEF_0123_4567, 1, mk(0, 0, 5'd0, 32'd0, 1, 6'd10, 32'h0123_4567));
        step(0, 1, 3'd0, 0, 2'd0, 5'd5, 32'd0, 64'hDEAD_BEEF_0123_4567, 0, mk(0, 0, 5'd0, 32'd0, 1, 6'd11, 32'hDEAD_BEEF));
        step(0, 1, 3'd0, 0, 2'd0, 5'd2, 32'd0, 64'hAAAA_0002_5555_0002, 1, mk(0, 0, 5'd0, 32'd0, 1, 6'd4, 32'h5555_0002));
        step(0, 1, 3'd0, 0, 2'd0, 5'd2, 32'd0, 64'hAAAA_0002_5555_0002, 0, mk(0, 0, 5'd0, 32'd0, 1, 6'd5, 32'hAAAA_0002));
        step(0, 1, 3'd0, 0, 2'd0, 5'd0, 32'd0, 64'hBBBB_0000_CCCC_0000, 1, mk(0, 0, 5'd0, 32'd0, 1, 6'd0, 32'hCCCC_0000));
        step(0, 1, 3'd0, 0, 2'd0, 5'd0, 32'd0, 64'hBBBB_0000_CCCC_0000, 0, mk(0, 0, 5'd0, 32'd0, 1, 6'd1, 32'hBBBB_0000));

        // Combined scalar + vector: one scalar write, with the low beat only
        step(0, 1, 3'd3, 0, 2'd0, 5'd9, 32'hCAFE_0009, 64'h9999_8888_7777_6666, 1, mk(0, 1, 5'd9, 32'hCAFE_0009, 1, 6'd18, 32'h7777_6666));
        step(0, 1, 3'd3, 0, 2'd0, 5'd9, 32'hCAFE_0009, 64'h9999_8888_7777_6666, 0, mk(0, 0, 5'd0, 32'd0, 1, 6'd19, 32'h9999_8888));

        // Reset while in HIGH drops the high beat; next vector starts in IDLE
        step(0, 1, 3'd0, 0, 2'd0, 5'd4, 32'd0, 64'hFEED_FACE_0BAD_F00D, 1, mk(0, 0, 5'd0, 32'd0, 1, 6'd8, 32'h0BAD_F00D));
        step(1, 1, 3'd0, 0, 2'd0, 5'd4, 32'd0, 64'hFEED_FACE_0BAD_F00D, 0, z);
        step(0, 0, 3'd0, 0, 2'd0, 5'd0, 32'd0, 64'd0, 0, mk(0, 0, 5'd0, 32'd0, 0, 6'd0, 32'd0));
        step(0, 1, 3'd0, 0, 2'd0, 5'd1, 32'd0, 64'h0000_00A1_0000_00A0, 1, mk(0, 0, 5'd0, 32'd0, 1, 6'd2, 32'h0000_00A0));
        step(0, 1, 3'd0, 0, 2'd0, 5'd1, 32'd0, 64'h0000_00A1_0000_00A0, 0, mk(0, 0, 5'd0, 32'd0, 1, 6'd3, 32'h0000_00A1));
        step(0, 0, 3'd0, 0, 2'd0, 5'd0, 32'd0, 64'd0, 0, mk(0, 0, 5'd0, 32'd0, 0, 6'd0, 32'd0));

        @(negedge clk);
        check_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
